// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/owner types and default bus widths for mem_arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
  typedef enum logic [1:0] {NONE, I, D} arb_owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, memory-stage port and main-memory bus of mem_arbiter
//   fetch : i_req, i_addr -> i_rvalid, i_rdata
//   data  : d_req, d_we, d_addr, d_wdata, d_wstrb -> d_rvalid, d_rdata
//   memory: mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb -> mem_ready, mem_rvalid, mem_rdata
//   master = arbiter side, slave = requesters plus memory model
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic i_req;
  logic [ADDR_W-1:0] i_addr;
  logic i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic d_req;
  logic d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic mem_req;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic mem_ready;
  logic mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rvalid, mem_rdata,
    output i_rvalid, i_rdata, d_rvalid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ready, mem_rvalid, mem_rdata,
    input  i_rvalid, i_rdata, d_rvalid, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between fetch and memory stage
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : mem_arbiter_if.master (requester ports and memory bus)
//   One transaction in flight; the memory stage wins ties. Defining ARB_FAIRNESS_EN
//   adds an age counter that forces a fetch grant after MAX_WAIT lost decisions.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef ARB_FAIRNESS_EN
  ,
  parameter int MAX_WAIT = 4
`endif
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  arb_state_t state;
  arb_owner_t owner;
  logic memReq;
  logic memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [STRB_W-1:0] memWstrb;
  logic iRvalid;
  logic dRvalid;
  logic [DATA_W-1:0] iRdata;
  logic [DATA_W-1:0] dRdata;
  logic dWin;
`ifdef ARB_FAIRNESS_EN
  localparam int AGE_W = $clog2(MAX_WAIT + 1);
  logic [AGE_W-1:0] age;
  // fetch is forced through once it has lost MAX_WAIT decisions in a row
  always_comb dWin = bus.d_req & ~(bus.i_req & (age == AGE_W'(MAX_WAIT)));
  // reaching MAX_WAIT always forces an I grant, which clears, so it never overflows
  always_ff @(posedge clk)
    if (!rst) age <= '0;
    else if (state == IDLE) age <= (bus.i_req && dWin) ? age + 1'b1 : '0;
`else
  always_comb dWin = bus.d_req;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      owner <= NONE;
      memReq <= 1'b0;
      memWe <= 1'b0;
      memAddr <= '0;
      memWdata <= '0;
      memWstrb <= '0;
      iRvalid <= 1'b0;
      dRvalid <= 1'b0;
      iRdata <= '0;
      dRdata <= '0;
    end else begin
      iRvalid <= 1'b0;
      dRvalid <= 1'b0;
      case (state)
        IDLE: if (bus.i_req || bus.d_req) begin
          state <= REQ;
          owner <= dWin ? D : I;
          memReq <= 1'b1;
          memWe <= dWin & bus.d_we;
          memAddr <= dWin ? bus.d_addr : bus.i_addr;
          memWdata <= dWin ? bus.d_wdata : '0;
          memWstrb <= dWin ? bus.d_wstrb : '0;
        end
        REQ: if (bus.mem_ready) begin
          state <= WAIT;
          memReq <= 1'b0;
        end
        WAIT: if (bus.mem_rvalid) begin
          state <= RESP;
          if (owner == D) begin
            dRvalid <= 1'b1;
            dRdata <= bus.mem_rdata;
          end else begin
            iRvalid <= 1'b1;
            iRdata <= bus.mem_rdata;
          end
        end
        default: begin
          state <= IDLE;
          owner <= NONE;
        end
      endcase
    end
  end
  assign bus.mem_req = memReq;
  assign bus.mem_we = memWe;
  assign bus.mem_addr = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.mem_wstrb = memWstrb;
  assign bus.i_rvalid = iRvalid;
  assign bus.i_rdata = iRdata;
  assign bus.d_rvalid = dRvalid;
  assign bus.d_rdata = dRdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  typedef struct {
    bit isD;
    bit chk;
    logic [31:0] data;
  } exp_t;
  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t monE;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // memory-side model for one transaction: optional ready stall, response latency
  task automatic serve(input bit isD, input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] strb, input int stall, input int lat, input logic [31:0] rdata,
                       input bit drop);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("mem_req_seen", bus.mem_req, 1);
    check("cmd_addr", bus.mem_addr, addr);
    check("cmd_we", bus.mem_we, we);
    check("cmd_wdata", bus.mem_wdata, wdata);
    check("cmd_wstrb", bus.mem_wstrb, strb);
    repeat (stall) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'hBAD0_0BAD;
      tick();
      check("stall_hold", {bus.mem_req, bus.mem_addr, bus.mem_we}, {1'b1, addr, we});
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("accept_drops_req", bus.mem_req, 0);
    repeat (lat - 1) begin
      bus.mem_ready = 1'b1;
      tick();
      bus.mem_ready = 1'b0;
    end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = rdata;
    sb.push_back('{isD: isD, chk: !(isD && we), data: rdata});
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    check(isD ? "d_rvalid_pulse" : "i_rvalid_pulse", isD ? bus.d_rvalid : bus.i_rvalid, 1);
    if (drop) begin
      if (isD) bus.d_req = 1'b0;
      else bus.i_req = 1'b0;
    end
  endtask
  always @(negedge clk)
    if (bus.i_rvalid === 1'b1 || bus.d_rvalid === 1'b1) begin
      if (sb.size() == 0) check("unexpected_rvalid", {bus.i_rvalid, bus.d_rvalid}, 2'b00);
      else begin
        monE = sb.pop_front();
        check("resp_owner", {bus.i_rvalid, bus.d_rvalid}, monE.isD ? 2'b01 : 2'b10);
        if (monE.chk) check("resp_rdata", monE.isD ? bus.d_rdata : bus.i_rdata, monE.data);
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit expD;
    rst = 1'b0;
    bus.i_req = 1'b1;
    bus.i_addr = 32'hBFC0_0000;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    check("rst_mem_cmd", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 0);
    check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    rst = 1'b1;
    tick();
    check("post_rst_mem_req", bus.mem_req, 1);
    check("post_rst_mem_addr", bus.mem_addr, 32'hBFC0_0000);
    serve(1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 4'h0, 0, 1, 32'h0010_0513, 1'b1);
    tick();
    check("fetch_pulse_len", bus.i_rvalid, 0);
    check("fetch_rdata_hold", bus.i_rdata, 32'h0010_0513);
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h0001_0000;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_wstrb = 4'hF;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0000_0100;
    tick();
    serve(1'b1, 32'h0001_0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1, 32'h5555_5555, 1'b1);
    serve(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 0, 2, 32'h1234_5678, 1'b1);
    tick();
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h0000_2000;
    bus.d_wdata = 32'h1111_2222;
    bus.d_wstrb = 4'h3;
    serve(1'b1, 32'h0000_2000, 1'b0, 32'h1111_2222, 4'h3, 5, 3, 32'hCAFE_F00D, 1'b1);
    tick();
    check("load_rdata_hold", bus.d_rdata, 32'hCAFE_F00D);
    check("fetch_rdata_kept", bus.i_rdata, 32'h1234_5678);
    bus.d_req = 1'b1;
    bus.d_addr = 32'h0000_3000;
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0000_4000;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_FAIRNESS_EN
      expD = (k != 4);
`else
      expD = 1'b1;
`endif
      serve(expD, expD ? 32'h0000_3000 : 32'h0000_4000, 1'b0, expD ? 32'h1111_2222 : 32'h0,
            expD ? 4'h3 : 4'h0, 0, 1, 32'hA000_0000 + 32'(k), 1'b0);
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    tick();
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0000_0300;
    tick();
    check("mw_mem_req", bus.mem_req, 1);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    rst = 1'b0;
    bus.i_req = 1'b0;
    tick();
    rst = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    check("mw_no_rvalid", {bus.i_rvalid, bus.d_rvalid}, 0);
    check("mw_mem_req_low", bus.mem_req, 0);
    check("mw_rdata_cleared", bus.i_rdata, 0);
    bus.i_req = 1'b1;
    bus.i_addr = 32'h0000_0400;
    tick();
    check("idle_after_rst", bus.mem_req, 1);
    serve(1'b0, 32'h0000_0400, 1'b0, 32'h0, 4'h0, 0, 1, 32'h7777_0001, 1'b1);
    tick();
    tick();
    check("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
